// File: rtl/acc_flag_trim_mc.sv
// Multi-channel accelerator flag trimmer: per-channel rise-delay/fall-hold FSM,
// bypass and off modes, and saturating pass/drop statistics gated by scan enable.
module acc_flag_trim_mc #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16,
    parameter int STAT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     scan_en_i,
    input  logic [CH_NUM-1:0]        flag_i,
    input  logic [2*CH_NUM-1:0]      mode_i,
    input  logic [CH_NUM*CNT_W-1:0]  delay_i,
    input  logic [CH_NUM*CNT_W-1:0]  hold_i,
    output logic [CH_NUM-1:0]        trim_ctrl_o,
    output logic [CH_NUM-1:0]        trim_flag_o,
    output logic [CH_NUM*STAT_W-1:0] pass_cnt_o,
    output logic [CH_NUM*STAT_W-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        ACTIVE    = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    logic scan_q;
    logic stat_clr;

    always_ff @(posedge clk_i) begin
        if (rst_i) scan_q <= 1'b0;
        else       scan_q <= scan_en_i;
    end

    // Statistics restart at the beginning of every scan.
    assign stat_clr = scan_en_i & ~scan_q;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [1:0]        mode;
        logic [1:0]        mode_q;
        logic [CNT_W-1:0]  delay;
        logic [CNT_W-1:0]  hold;
        logic              flag_r;
        logic              byp_r;
        logic              trim_r;
        logic              trim_q;
        logic              abort;
        state_t            state;
        state_t            state_nx;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  cnt_nx;
        logic [CNT_W-1:0]  d_lat;
        logic [CNT_W-1:0]  d_nx;
        logic [CNT_W-1:0]  h_lat;
        logic [CNT_W-1:0]  h_nx;
        logic [STAT_W-1:0] pass_cnt;
        logic [STAT_W-1:0] drop_cnt;

        assign mode  = mode_i[2*c +: 2];
        assign delay = delay_i[c*CNT_W +: CNT_W];
        assign hold  = hold_i[c*CNT_W +: CNT_W];

        assign trim_ctrl_o[c]                   = flag_r;
        assign trim_flag_o[c]                   = trim_r;
        assign pass_cnt_o[c*STAT_W +: STAT_W]   = pass_cnt;
        assign drop_cnt_o[c*STAT_W +: STAT_W]   = drop_cnt;

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            d_nx     = d_lat;
            h_nx     = h_lat;
            abort    = 1'b0;
            // Disabled scan, non-trim mode or a mode change park the channel silently.
            if (!scan_en_i || !mode[1] || (mode != mode_q)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (flag_r) begin
                            d_nx   = delay;
                            h_nx   = hold;
                            cnt_nx = '0;
                            if (delay == '0) state_nx = ACTIVE;
                            else             state_nx = RISE_WAIT;
                        end
                    end
                    RISE_WAIT: begin
                        if (!flag_r) begin
                            state_nx = IDLE;
                            abort    = 1'b1;
                        end else if (cnt == d_lat - CNT_W'(1)) begin
                            state_nx = ACTIVE;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                    ACTIVE: begin
                        if (!flag_r) begin
                            cnt_nx = '0;
                            if (h_lat == '0) state_nx = IDLE;
                            else             state_nx = FALL_WAIT;
                        end
                    end
                    FALL_WAIT: begin
                        if (flag_r) begin
                            state_nx = ACTIVE;
                        end else if (cnt == h_lat - CNT_W'(1)) begin
                            state_nx = IDLE;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                flag_r <= 1'b0;
                byp_r  <= 1'b0;
                trim_r <= 1'b0;
                trim_q <= 1'b0;
                mode_q <= '0;
                state  <= IDLE;
                cnt    <= '0;
                d_lat  <= '0;
                h_lat  <= '0;
            end else begin
                flag_r <= flag_i[c];
                byp_r  <= flag_r;
                trim_q <= trim_r;
                mode_q <= mode;
                state  <= state_nx;
                cnt    <= cnt_nx;
                d_lat  <= d_nx;
                h_lat  <= h_nx;
                if (!scan_en_i) begin
                    trim_r <= 1'b0;
                end else begin
                    case (mode)
                        2'b00:   trim_r <= 1'b0;
                        2'b01:   trim_r <= byp_r;
                        default: trim_r <= (state == ACTIVE) || (state == FALL_WAIT);
                    endcase
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i || stat_clr) begin
                pass_cnt <= '0;
                drop_cnt <= '0;
            end else begin
                if (scan_en_i && trim_r && !trim_q && (pass_cnt != {STAT_W{1'b1}}))
                    pass_cnt <= pass_cnt + STAT_W'(1);
                if (abort && (drop_cnt != {STAT_W{1'b1}}))
                    drop_cnt <= drop_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_flag_trim_mc.sv
// Directed self-checking bench for acc_flag_trim_mc with hand-computed waveforms
// (4 channels, 8-bit delay/hold, 4-bit statistics to reach saturation quickly).
module tb_acc_flag_trim_mc;

    localparam int CH  = 4;
    localparam int CW  = 8;
    localparam int SW  = 4;

    logic             clk;
    logic             rst_i;
    logic             scan_en_i;
    logic [CH-1:0]    flag_i;
    logic [2*CH-1:0]  mode_i;
    logic [CH*CW-1:0] delay_i;
    logic [CH*CW-1:0] hold_i;
    logic [CH-1:0]    trim_ctrl_o;
    logic [CH-1:0]    trim_flag_o;
    logic [CH*SW-1:0] pass_cnt_o;
    logic [CH*SW-1:0] drop_cnt_o;

    int total = 0;
    int bad   = 0;

    acc_flag_trim_mc #(.CH_NUM(CH), .CNT_W(CW), .STAT_W(SW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .scan_en_i   (scan_en_i),
        .flag_i      (flag_i),
        .mode_i      (mode_i),
        .delay_i     (delay_i),
        .hold_i      (hold_i),
        .trim_ctrl_o (trim_ctrl_o),
        .trim_flag_o (trim_flag_o),
        .pass_cnt_o  (pass_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bits [a, b) set; waveform bit k is the flag driven for cycle k.
    function automatic logic [63:0] span(input int a, input int b);
        logic [63:0] m;
        m = '0;
        for (int i = a; i < b; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Input driven before edge k is visible on trim_flag_o two edges after flag_r.
    task automatic applyStimulus(input int ch, input logic [63:0] in_wave, input logic [63:0] exp_wave,
                                 input int len, input string tag, input int chg_idx,
                                 input logic [CW-1:0] chg_val);
        for (int k = 0; k < len; k++) begin
            flag_i[ch] = in_wave[k];
            if (k == chg_idx) delay_i[ch*CW +: CW] = chg_val;
            tick(1);
            checkOutput($sformatf("%s[%0d]", tag, k), {31'd0, trim_flag_o[ch]}, {31'd0, exp_wave[k]});
        end
        flag_i[ch] = 1'b0;
    endtask

    function automatic logic [31:0] passOf(input int ch);
        return {28'd0, pass_cnt_o[ch*SW +: SW]};
    endfunction

    function automatic logic [31:0] dropOf(input int ch);
        return {28'd0, drop_cnt_o[ch*SW +: SW]};
    endfunction

    initial begin
        rst_i     = 1'b1;
        scan_en_i = 1'b1;
        flag_i    = 4'hF;
        mode_i    = 8'b10_10_10_10;
        delay_i   = {8'd0, 8'd1, 8'd3, 8'd3};
        hold_i    = {8'd0, 8'd4, 8'd2, 8'd2};

        $display("[TB] reset state");
        tick(3);
        checkOutput("rst_ctrl", {28'd0, trim_ctrl_o}, 32'd0);
        checkOutput("rst_flag", {28'd0, trim_flag_o}, 32'd0);
        checkOutput("rst_pass", {16'd0, pass_cnt_o}, 32'd0);
        checkOutput("rst_drop", {16'd0, drop_cnt_o}, 32'd0);
        flag_i = '0;
        tick(1);
        rst_i = 1'b0;
        tick(2);

        $display("[TB] ch0 D=3 H=2 ten-cycle pulse");
        applyStimulus(0, span(2, 12), span(7, 16), 24, "a_flag", -1, '0);
        checkOutput("a_pass", passOf(0), 32'd1);
        checkOutput("a_drop", dropOf(0), 32'd0);

        $display("[TB] ch1 D=3 pulses of 3 and 4 cycles");
        applyStimulus(1, span(2, 5) | span(10, 14), span(15, 18), 24, "b_flag", -1, '0);
        checkOutput("b_pass", passOf(1), 32'd1);
        checkOutput("b_drop", dropOf(1), 32'd1);

        $display("[TB] ch2 D=1 H=4 gaps of 4 and 5 cycles");
        applyStimulus(2, span(2, 6) | span(10, 14) | span(19, 23), span(5, 20) | span(22, 29), 32,
                      "c_flag", -1, '0);
        checkOutput("c_pass", passOf(2), 32'd2);
        checkOutput("c_drop", dropOf(2), 32'd0);

        $display("[TB] ch3 D=0 H=0 trim, bypass, off");
        applyStimulus(3, span(2, 3), span(4, 5), 8, "d_trim", -1, '0);
        mode_i[7:6] = 2'b01;
        applyStimulus(3, span(2, 3), span(4, 5), 8, "d_byp", -1, '0);
        checkOutput("d_pass_byp", passOf(3), 32'd2);
        mode_i[7:6] = 2'b00;
        applyStimulus(3, span(2, 3), 64'd0, 8, "d_off", -1, '0);
        checkOutput("d_pass_off", passOf(3), 32'd2);
        mode_i[7:6] = 2'b10;
        tick(2);

        $display("[TB] scan enable drop and restart");
        flag_i = 4'b1001;
        tick(8);
        checkOutput("e_flag_on", {28'd0, trim_flag_o}, 32'h9);
        checkOutput("e_pass0_on", passOf(0), 32'd2);
        checkOutput("e_pass3_on", passOf(3), 32'd3);
        scan_en_i = 1'b0;
        tick(1);
        checkOutput("e_flag_off", {28'd0, trim_flag_o}, 32'd0);
        checkOutput("e_ctrl_live", {28'd0, trim_ctrl_o}, 32'h9);
        tick(3);
        checkOutput("e_pass0_hold", passOf(0), 32'd2);
        checkOutput("e_pass3_hold", passOf(3), 32'd3);
        checkOutput("e_drop1_hold", dropOf(1), 32'd1);
        checkOutput("e_flag_stay", {28'd0, trim_flag_o}, 32'd0);
        flag_i = '0;
        tick(1);
        scan_en_i = 1'b1;
        tick(1);
        checkOutput("e_pass_clr", {16'd0, pass_cnt_o}, 32'd0);
        checkOutput("e_drop_clr", {16'd0, drop_cnt_o}, 32'd0);
        tick(3);
        checkOutput("e_flag_idle", {28'd0, trim_flag_o}, 32'd0);

        $display("[TB] ch3 pass counter saturation");
        for (int i = 0; i < 20; i++) begin
            flag_i[3] = 1'b1;
            tick(1);
            flag_i[3] = 1'b0;
            tick(3);
            if (i == 9)  checkOutput("f_pass_10", passOf(3), 32'd10);
            if (i == 14) checkOutput("f_pass_15", passOf(3), 32'd15);
        end
        checkOutput("f_pass_sat", passOf(3), 32'd15);

        $display("[TB] ch0 delay change mid-pulse");
        applyStimulus(0, span(2, 12) | span(20, 30), span(7, 16) | span(28, 34), 36, "g_flag", 4, 8'd6);
        checkOutput("g_pass", passOf(0), 32'd2);
        checkOutput("g_drop", dropOf(0), 32'd0);

        $display("[TB] reset during an output pulse");
        flag_i[0] = 1'b1;
        tick(10);
        checkOutput("h_flag_pre", {31'd0, trim_flag_o[0]}, 32'd1);
        rst_i = 1'b1;
        tick(1);
        checkOutput("h_flag_rst", {28'd0, trim_flag_o}, 32'd0);
        checkOutput("h_ctrl_rst", {28'd0, trim_ctrl_o}, 32'd0);
        checkOutput("h_pass_rst", {16'd0, pass_cnt_o}, 32'd0);
        flag_i = '0;
        tick(1);
        rst_i = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
